// File: rtl/fxp_divider.sv
// Sequential signed fixed-point divider: quotient = (a << FRAC) / b, truncated toward zero,
// saturated on overflow or divide-by-zero. One restoring-division bit per cycle, fixed latency.
module fxp_divider #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic             overflow,
  output logic             div_by_zero
);

  localparam int N  = WIDTH + FRAC;
  localparam int CW = $clog2(N + 1);
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     work_q, work_d;
  logic [WIDTH:0]   divisor_q, divisor_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             a_neg_q, a_neg_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic             ovf_q, ovf_d;
  logic             dbzo_q, dbzo_d;

  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   fix;

  // Magnitude one bit wider than the operand so |-2^(WIDTH-1)| is exact.
  function automatic logic [WIDTH:0] abs_ext(input logic signed [WIDTH-1:0] v);
    if (v[WIDTH-1]) return {1'b0, ~v} + (WIDTH+1)'(1);
    return {1'b0, v};
  endfunction

  // Returns {overflow, quotient} from the unsigned magnitude and latched sign flags.
  function automatic logic [WIDTH:0] fixup(input logic [N-1:0] q, input logic neg,
                                           input logic a_neg, input logic zero_div);
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] qneg;
    qn   = q[WIDTH-1:0];
    qneg = ~qn + 1'b1;
    if (zero_div) return {1'b0, a_neg ? NEG_MIN : POS_MAX};
    if (!neg)     return (q > N'(POS_MAX)) ? {1'b1, POS_MAX} : {1'b0, qn};
    return (q > N'(NEG_MIN)) ? {1'b1, NEG_MIN} : {1'b0, qneg};
  endfunction

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    sign_d    = sign_q;
    a_neg_d   = a_neg_q;
    dbz_d     = dbz_q;
    quot_d    = quot_q;
    ovf_d     = ovf_q;
    dbzo_d    = dbzo_q;
    trial     = {rem_q, work_q[N-1]};
    diff      = trial - {1'b0, divisor_q};
    fix       = fixup(work_q, sign_q, a_neg_q, dbz_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d    = a[WIDTH-1] ^ b[WIDTH-1];
          a_neg_d   = a[WIDTH-1];
          divisor_d = abs_ext(b);
          work_d    = N'(abs_ext(a)) << FRAC;
          dbz_d     = (b == '0);
          rem_d     = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        // After the last bit, one extra edge registers the saturated result.
        if (cnt_q == CW'(N)) begin
          {ovf_d, quot_d} = fix;
          dbzo_d          = dbz_q;
          state_d         = DONE;
        end else begin
          if (trial >= {1'b0, divisor_q}) begin
            rem_d  = diff[WIDTH:0];
            work_d = {work_q[N-2:0], 1'b1};
          end else begin
            rem_d  = trial[WIDTH:0];
            work_d = {work_q[N-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      work_q    <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      a_neg_q   <= 1'b0;
      dbz_q     <= 1'b0;
      quot_q    <= '0;
      ovf_q     <= 1'b0;
      dbzo_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      sign_q    <= sign_d;
      a_neg_q   <= a_neg_d;
      dbz_q     <= dbz_d;
      quot_q    <= quot_d;
      ovf_q     <= ovf_d;
      dbzo_q    <= dbzo_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbzo_q;

endmodule

// File: tb/tb_fxp_divider.sv
// Scoreboard bench for fxp_divider: driver queues hand-computed results, a negedge monitor
// pops and compares on every rising out_valid, including accept-to-valid latency.
module tb_fxp_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic        overflow;
  logic        div_by_zero;

  typedef struct {
    logic [15:0] q;
    logic        ovf;
    logic        dbz;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_ov = 1'b0;

  fxp_divider #(.WIDTH(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // Monitor: compare on each rising out_valid against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && in_valid && in_ready) acc_cyc = cyc + 1;
    if (out_valid && !prev_ov) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("overflow", 32'(overflow), 32'(e.ovf));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
        chk("latency", 32'(cyc - acc_cyc), 32'd25);
      end
    end
    prev_ov = out_valid;
  end

  // Caller sits at posedge+#1; returns at posedge+#1 just after the accept edge.
  task automatic issue(input logic [15:0] aa, input logic [15:0] bb, input logic [15:0] eq,
                       input logic eo, input logic ed, input bit push);
    int t;
    exp_t e;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    e.q = eq; e.ovf = eo; e.dbz = ed;
    if (push) exp_q.push_back(e);
    a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_quotient"}, 32'(quotient), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_div_by_zero"}, 32'(div_by_zero), 32'd0);
  endtask

  logic [15:0] va [11] = '{16'h0100, 16'hFD00, 16'h0100, 16'hFF00, 16'h0001, 16'h7FFF,
                           16'h8000, 16'h8000, 16'h8000, 16'hFF00, 16'h0000};
  logic [15:0] vb [11] = '{16'h0200, 16'h0200, 16'h0300, 16'h0300, 16'h7FFF, 16'h0001,
                           16'h0001, 16'hFF00, 16'h0100, 16'h0000, 16'h0000};
  logic [15:0] vq [11] = '{16'h0080, 16'hFE80, 16'h0055, 16'hFFAB, 16'h0000, 16'h7FFF,
                           16'h8000, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF};
  logic        vo [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        vd [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    int t;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) issue(va[i], vb[i], vq[i], vo[i], vd[i], 1'b1);
    issue(16'h0000, 16'hFE00, 16'h0000, 1'b0, 1'b0, 1'b1);
    drain();

    // Backpressure: hold the result in DONE while in_valid pulses are ignored.
    out_ready = 1'b0;
    issue(16'h0300, 16'h0100, 16'h0300, 1'b0, 1'b0, 1'b1);
    t = 0;
    while (!out_valid && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    chk("hold_out_valid_seen", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; a = 16'h7FFF; b = 16'h0001;
      @(negedge clk);
      chk("hold_quotient", 32'(quotient), 32'h0300);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    issue(16'h0100, 16'hFF00, 16'hFF00, 1'b0, 1'b0, 1'b1);
    drain();

    // Abandon an operation with an asynchronous reset at CALC iteration 7.
    issue(16'h7000, 16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_reset_no_valid", 32'(out_valid), 32'd0);
    issue(16'h0200, 16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
